// File: rtl/mem_dbus_ctrl.sv
// Memory-stage data-bus controller: turns a load/store from the MEM stage into a
// split address/data bus transaction and stalls MEM/WB until the access retires.
module mem_dbus_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,
    input  logic              mem_req_valid,
    input  logic              mem_req_wr,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [DATA_W-1:0] mem_req_wdata,
    input  logic [3:0]        mem_req_be,
    input  logic              flush,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stop_wb,
    output logic              mem_acc_done,
    output logic [2:0]        fsm_state
);

    // Bus handshake: data_req is held with stable address/data until data_addr_ok;
    // exactly one data_data_ok follows, no earlier than the cycle after addr_ok.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        DATA    = 3'd2,
        DONE    = 3'd3,
        DISCARD = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_be;
    logic              req_wr;
    logic              accept;
    logic              load_capture;

    assign accept       = (state == IDLE) && mem_req_valid && !flush;
    assign load_capture = (state == DATA) && data_data_ok && !flush && !req_wr;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ADDR;
            ADDR: begin
                if (data_addr_ok) state_nxt = flush ? DISCARD : DATA;
                else if (flush)   state_nxt = IDLE;
            end
            DATA: begin
                if (data_data_ok) state_nxt = flush ? IDLE : DONE;
                else if (flush)   state_nxt = DISCARD;
            end
            DONE:    state_nxt = IDLE;
            DISCARD: if (data_data_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_req     = (state == ADDR);
        mem_acc_done = (state == DONE);
        // Reset gating keeps the stall low even if the pipeline drives valid during reset.
        mem_stop_wb  = cpu_rst_n && (accept || (state == ADDR) || (state == DATA) ||
                                     ((state == DISCARD) && mem_req_valid));
        fsm_state    = state;
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            req_wr    <= 1'b0;
        end else if (accept) begin
            req_addr  <= mem_req_addr;
            req_wdata <= mem_req_wdata;
            req_be    <= mem_req_be;
            req_wr    <= mem_req_wr;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            mem_rdata <= '0;
        end else if (load_capture) begin
            mem_rdata <= data_rdata;
        end
    end

    always_comb begin
        case (req_be)
            4'b1111:          data_size = 2'd2;
            4'b0011, 4'b1100: data_size = 2'd1;
            default:          data_size = 2'd0;
        endcase
    end

    assign data_wr    = req_wr;
    assign data_addr  = req_addr;
    assign data_wdata = req_wdata;
    assign data_wstrb = req_wr ? req_be : 4'b0000;

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed bench for mem_dbus_ctrl: inputs change 1ns after the rising edge and
// outputs are checked 2ns after it, well away from the next active edge.
module tb_mem_dbus_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_DISCARD = 3'd4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_req_valid;
    logic              mem_req_wr;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [3:0]        mem_req_be;
    logic              flush;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [3:0]        data_wstrb;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_stop_wb;
    logic              mem_acc_done;
    logic [2:0]        fsm_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_dbus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .cpu_clk_50M   (clk),
        .cpu_rst_n     (rst_n),
        .mem_req_valid (mem_req_valid),
        .mem_req_wr    (mem_req_wr),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_be    (mem_req_be),
        .flush         (flush),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_wstrb    (data_wstrb),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata),
        .mem_rdata     (mem_rdata),
        .mem_stop_wb   (mem_stop_wb),
        .mem_acc_done  (mem_acc_done),
        .fsm_state     (fsm_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to 1ns after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic set_req(input logic v, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
        mem_req_valid = v;
        mem_req_wr    = wr;
        mem_req_addr  = a;
        mem_req_wdata = wd;
        mem_req_be    = be;
    endtask

    task automatic check_ctl(input string tag, input logic [2:0] st, input logic req,
                             input logic stop, input logic done);
        check({tag, "_state"}, {29'd0, fsm_state}, {29'd0, st});
        check({tag, "_req"},   {31'd0, data_req}, {31'd0, req});
        check({tag, "_stop"},  {31'd0, mem_stop_wb}, {31'd0, stop});
        check({tag, "_done"},  {31'd0, mem_acc_done}, {31'd0, done});
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata = '0;
        set_req(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);

        // Reset: everything low, stall forced low despite valid
        repeat (2) tick();
        settle();
        check_ctl("rst", S_IDLE, 1'b0, 1'b0, 1'b0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_addr", data_addr, 32'h0);
        check("rst_wdata", data_wdata, 32'h0);
        check("rst_wstrb", {28'd0, data_wstrb}, 32'h0);
        check("rst_size", {30'd0, data_size}, 32'h0);
        check("rst_wr", {31'd0, data_wr}, 32'h0);
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        rst_n = 1'b1;

        // Word load, addr_ok first ADDR cycle, data_ok two cycles later
        tick();
        set_req(1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'hF);
        settle();
        check_ctl("wl_idle", S_IDLE, 1'b0, 1'b1, 1'b0);
        tick();
        data_addr_ok = 1'b1;
        settle();
        check_ctl("wl_addr", S_ADDR, 1'b1, 1'b1, 1'b0);
        check("wl_size", {30'd0, data_size}, 32'd2);
        check("wl_baddr", data_addr, 32'h1000_0004);
        check("wl_wstrb", {28'd0, data_wstrb}, 32'h0);
        check("wl_wr", {31'd0, data_wr}, 32'h0);
        tick();
        data_addr_ok = 1'b0;
        settle();
        check_ctl("wl_data1", S_DATA, 1'b0, 1'b1, 1'b0);
        tick();
        data_data_ok = 1'b1;
        data_rdata = 32'hDEAD_BEEF;
        settle();
        check_ctl("wl_data2", S_DATA, 1'b0, 1'b1, 1'b0);
        tick();
        data_data_ok = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        check_ctl("wl_done", S_DONE, 1'b0, 1'b0, 1'b1);
        check("wl_rdata", mem_rdata, 32'hDEAD_BEEF);
        tick();
        settle();
        check_ctl("wl_after", S_IDLE, 1'b0, 1'b0, 1'b0);

        // Byte store, addr_ok delayed 3 cycles; request must stay latched
        set_req(1'b1, 1'b1, 32'h2000_0002, 32'h00AB_0000, 4'b0100);
        tick();
        set_req(1'b1, 1'b1, 32'h9999_9999, 32'h1111_1111, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            settle();
            check_ctl("bs_wait", S_ADDR, 1'b1, 1'b1, 1'b0);
            check("bs_addr", data_addr, 32'h2000_0002);
            check("bs_wdata", data_wdata, 32'h00AB_0000);
            tick();
        end
        data_addr_ok = 1'b1;
        settle();
        check_ctl("bs_aok", S_ADDR, 1'b1, 1'b1, 1'b0);
        check("bs_wr", {31'd0, data_wr}, 32'h1);
        check("bs_wstrb", {28'd0, data_wstrb}, 32'h4);
        check("bs_size", {30'd0, data_size}, 32'd0);
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata = 32'h5A5A_5A5A;
        settle();
        check_ctl("bs_data", S_DATA, 1'b0, 1'b1, 1'b0);
        tick();
        data_data_ok = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        check_ctl("bs_done", S_DONE, 1'b0, 1'b0, 1'b1);
        check("bs_rdata", mem_rdata, 32'hDEAD_BEEF);
        tick();

        // Flush in ADDR without addr_ok: withdrawn, no retire
        set_req(1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'b0011);
        tick();
        flush = 1'b1;
        settle();
        check_ctl("fa_addr", S_ADDR, 1'b1, 1'b1, 1'b0);
        check("fa_size", {30'd0, data_size}, 32'd1);
        tick();
        flush = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        check_ctl("fa_idle", S_IDLE, 1'b0, 1'b0, 1'b0);

        // Flush coinciding with addr_ok: DISCARD, late data dropped
        set_req(1'b1, 1'b0, 32'h3000_0010, 32'h0, 4'b1100);
        tick();
        flush = 1'b1;
        data_addr_ok = 1'b1;
        tick();
        flush = 1'b0;
        data_addr_ok = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        check_ctl("fd_disc", S_DISCARD, 1'b0, 1'b0, 1'b0);
        tick();
        data_data_ok = 1'b1;
        data_rdata = 32'h1234_5678;
        tick();
        data_data_ok = 1'b0;
        settle();
        check_ctl("fd_idle", S_IDLE, 1'b0, 1'b0, 1'b0);
        check("fd_rdata", mem_rdata, 32'hDEAD_BEEF);

        // New load waits in stall while DISCARD drains
        set_req(1'b1, 1'b0, 32'h3000_0020, 32'h0, 4'hF);
        tick();
        flush = 1'b1;
        data_addr_ok = 1'b1;
        tick();
        flush = 1'b0;
        data_addr_ok = 1'b0;
        set_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
        settle();
        check_ctl("nd_disc1", S_DISCARD, 1'b0, 1'b1, 1'b0);
        tick();
        settle();
        check_ctl("nd_disc2", S_DISCARD, 1'b0, 1'b1, 1'b0);
        tick();
        data_data_ok = 1'b1;
        data_rdata = 32'h0000_0055;
        settle();
        check_ctl("nd_drain", S_DISCARD, 1'b0, 1'b1, 1'b0);
        tick();
        data_data_ok = 1'b0;
        settle();
        check_ctl("nd_idle", S_IDLE, 1'b0, 1'b1, 1'b0);
        check("nd_rdata_hold", mem_rdata, 32'hDEAD_BEEF);
        tick();
        data_addr_ok = 1'b1;
        settle();
        check_ctl("nd_addr", S_ADDR, 1'b1, 1'b1, 1'b0);
        check("nd_baddr", data_addr, 32'h0000_0040);
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata = 32'hCAFE_0001;
        tick();
        data_data_ok = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        check_ctl("nd_done", S_DONE, 1'b0, 1'b0, 1'b1);
        check("nd_rdata", mem_rdata, 32'hCAFE_0001);
        tick();

        // Async reset while in DATA; stray data_ok afterwards ignored
        set_req(1'b1, 1'b0, 32'h0000_0050, 32'h0, 4'hF);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        settle();
        check_ctl("ar_data", S_DATA, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        settle();
        check_ctl("ar_rst", S_IDLE, 1'b0, 1'b0, 1'b0);
        check("ar_rdata", mem_rdata, 32'h0);
        check("ar_addr", data_addr, 32'h0);
        tick();
        rst_n = 1'b1;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        data_data_ok = 1'b1;
        data_rdata = 32'h0000_0077;
        tick();
        data_data_ok = 1'b0;
        settle();
        check_ctl("ar_stray", S_IDLE, 1'b0, 1'b0, 1'b0);
        check("ar_stray_rdata", mem_rdata, 32'h0);

        // Back-to-back loads to 0x0 and 0x4 with one DONE cycle between
        set_req(1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata = 32'h1111_1111;
        tick();
        data_data_ok = 1'b0;
        set_req(1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'hF);
        settle();
        check_ctl("bb_done1", S_DONE, 1'b0, 1'b0, 1'b1);
        check("bb_rdata1", mem_rdata, 32'h1111_1111);
        tick();
        settle();
        check_ctl("bb_idle", S_IDLE, 1'b0, 1'b1, 1'b0);
        tick();
        data_addr_ok = 1'b1;
        settle();
        check_ctl("bb_addr2", S_ADDR, 1'b1, 1'b1, 1'b0);
        check("bb_baddr2", data_addr, 32'h0000_0004);
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata = 32'h2222_2222;
        tick();
        data_data_ok = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        check_ctl("bb_done2", S_DONE, 1'b0, 1'b0, 1'b1);
        check("bb_rdata2", mem_rdata, 32'h2222_2222);
        tick();
        settle();
        check_ctl("bb_end", S_IDLE, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_dbus_ctrl.md
Name: mem_dbus_ctrl

Overview:
Memory-stage data-bus controller that sits directly upstream of the MEM/WB pipeline register. It turns a load/store request from the memory stage into an SRAM-like split-transaction access (separate address and data handshakes). It returns the load word as mem_rdata and raises mem_stop_wb so the MEM/WB register holds its state until the access completes.

Parameters:
ADDR_W, 32, data address width
DATA_W, 32, data word width

Ports:
cpu_clk_50M  in  1  system clock, all state on rising edge
cpu_rst_n  in  1  reset, asynchronous, active-low
mem_req_valid  in  1  memory-stage instruction needs a data access this cycle
mem_req_wr  in  1  1 = store, 0 = load
mem_req_addr  in  ADDR_W  byte address
mem_req_wdata  in  DATA_W  store data, already lane-aligned
mem_req_be  in  4  byte lanes accessed: 0001/0010/0100/1000, 0011/1100, or 1111
flush  in  1  exception/flush from CP0, kills the current access
data_req  out  1  bus request valid
data_wr  out  1  bus write
data_size  out  2  0 = byte, 1 = half, 2 = word
data_addr  out  ADDR_W  bus address
data_wdata  out  DATA_W  bus write data
data_wstrb  out  4  write strobes; 0000 on loads
data_addr_ok  in  1  address/request accepted this cycle
data_data_ok  in  1  read data valid / write complete this cycle
data_rdata  in  DATA_W  read data
mem_rdata  out  DATA_W  load word to MEM/WB register
mem_stop_wb  out  1  stall: MEM/WB must hold, upstream must not advance
mem_acc_done  out  1  one-cycle pulse when an access retires

Behaviour:
- Reset: the clock is cpu_clk_50M; reset is asynchronous, active-low on cpu_rst_n.
  - Reset forces state IDLE and clears all request registers.
  - Reset values: mem_rdata = 0, data_req = 0, data_wr = 0, data_size = 0, data_addr = 0, data_wdata = 0, data_wstrb = 0, mem_acc_done = 0.
  - mem_stop_wb is forced to 0 while cpu_rst_n = 0.
- Reset mid-access: the FSM returns to IDLE immediately. Any data_ok that arrives afterwards is ignored.
- States: IDLE, ADDR, DATA, DONE, DISCARD.
- IDLE:
  - mem_req_valid = 1 and flush = 0: latch addr, wdata, be and wr into request registers; go to ADDR.
  - data_size is derived from be: 1111 -> 2, 0011/1100 -> 1, single lane -> 0.
  - data_wstrb = be on stores, 0000 on loads.
- ADDR:
  - data_req = 1, driven only from the request registers.
  - data_addr_ok = 1: go to DATA.
  - flush = 1 and data_addr_ok = 0: request withdrawn, go to IDLE.
  - flush = 1 and data_addr_ok = 1: go to DISCARD.
- DATA:
  - data_req = 0.
  - data_data_ok = 1 and flush = 0: go to DONE; on a load, capture data_rdata into mem_rdata.
  - data_data_ok = 1 and flush = 1: drop the data, go to IDLE.
  - data_data_ok = 0 and flush = 1: go to DISCARD.
- DONE:
  - Exactly one cycle: mem_acc_done = 1, mem_stop_wb = 0, then go to IDLE.
  - No new request is launched from DONE, even if mem_req_valid = 1. The upstream instruction advances on this edge.
- DISCARD:
  - data_req = 0; wait for data_data_ok, drop it, go to IDLE.
  - mem_rdata is not updated.
- mem_stop_wb (combinational) = (IDLE & mem_req_valid & ~flush) | ADDR | DATA | (DISCARD & mem_req_valid).
  - A new request waits in IDLE with stall set until DISCARD drains.
- mem_rdata changes only on a load completing in DATA. It holds its value across stores, flushes and idle cycles.
- Protocol rules:
  - The earliest data_data_ok is the cycle after the data_addr_ok cycle.
  - One outstanding transaction at most.
  - data_data_ok seen in IDLE, ADDR or DONE is a protocol error and is ignored.
- Latency: minimum load = 4 cycles from mem_req_valid to mem_acc_done (IDLE, ADDR with addr_ok, DATA with data_ok, DONE).
- Address is passed unmodified; the alignment exception is raised upstream, never here.

Test Plan:
- Word load: valid, addr 0x1000_0004, be 1111, addr_ok on the 1st ADDR cycle, data_ok 2 cycles later with 0xDEADBEEF -> data_size = 2, stall high until DONE, mem_rdata = 0xDEADBEEF, one mem_acc_done pulse.
- Byte store: be 0100, wdata 0x00AB0000, addr_ok delayed 3 cycles -> data_req held 3+1 cycles with stable addr, data_wr = 1, data_wstrb = 0100, data_size = 0; mem_rdata unchanged.
- Flush in ADDR without addr_ok -> data_req drops next cycle, IDLE, no mem_acc_done. Flush coinciding with addr_ok -> DISCARD; a later data_ok of 0x12345678 leaves mem_rdata unchanged.
- New valid load during DISCARD -> stall stays 1, no data_req until the old data_ok arrives; then the normal sequence follows.
- Async reset asserted while in DATA -> all outputs 0 immediately (mem_rdata = 0); a stray data_ok after release is ignored.
- Back-to-back loads to 0x0 and 0x4 -> exactly one DONE cycle between them, with mem_stop_wb = 0 in that cycle.
